branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Parametrised next-generation conditional-branch controller. Merges the EX-stage
//   branch evaluator, an indexed table of 2-bit saturating predictors, misprediction
//   detection and pipeline-flush sequencing in one block.
//  Sits between IF (prediction lookup) and EX (resolution). Drives the corrected next
//   PC and a multi-cycle flush to the front-end stages.
// PARAMETERS
//  WordSize     32    datapath / PC width
//  IdxBits      6     predictor index width; table depth = 2**IdxBits entries
//  InitState    2'b01 reset value of every counter (weakly not-taken)
//  FlushCycles  2     cycles flush stays asserted after a mispredict (>=1)
//  CntW         16    width of the mispredict statistics counter
// PORTS
//  clk            in   1         clock, all state on rising edge
//  rst            in   1         reset, asynchronous, active-high
//  if_pc          in   WordSize  fetch PC to predict
//  pred_taken     out  1         prediction for if_pc (combinational)
//  ex_valid       in   1         EX holds a conditional branch this cycle
//  ex_pc          in   WordSize  PC of the EX branch (update index)
//  ex_pred_taken  in   1         prediction carried down the pipe with the branch
//  branch_cond    in   2         00 never, 01 EQ, 10 NE, 11 LT
//  alu_out        in   WordSize  compare result (rs1 - rs2) from ALU
//  ex_target      in   WordSize  branch target address
//  ex_pc_plus4    in   WordSize  fall-through address
//  act_taken      out  1         resolved direction (combinational)
//  flush          out  1         flush IF/ID, held FlushCycles cycles
//  npc            out  WordSize  corrected next PC, valid while flush=1
//  mispredict_cnt out  CntW      saturating count of mispredictions
// BEHAVIOUR
//  Reset (async, rst=1): every table entry <= InitState; flush=0; npc=0;
//   mispredict_cnt=0; flush counter=0. Outputs valid same cycle rst rises.
//  Index: idx = pc[IdxBits+1:2] (word-aligned PCs; bits [1:0] ignored).
//  Predict: pred_taken = table[idx(if_pc)][1]; zero-latency read, no bypass:
//   same-cycle write to same entry is NOT visible until the next cycle.
//  Evaluate: act_taken = 00:0; 01:(alu_out==0); 10:(alu_out!=0); 11:alu_out[WordSize-1].
//   Computed regardless of ex_valid; consumers qualify with ex_valid.
//  Accepted branch: acc = ex_valid & ~flush. While flush=1, ex_valid is a wrong-path
//   instruction: no table update, no mispredict detection, no count.
//  Update on acc, next edge: taken -> entry=min(entry+1,3); not-taken ->
//   entry=max(entry-1,0). Saturates at 2'b11 / 2'b00, never wraps.
//  Mispredict: mp = acc & (act_taken != ex_pred_taken).
//  Flush FSM: IDLE -> (mp) FLUSH, loading cnt=FlushCycles-1 and
//   npc = act_taken ? ex_target : ex_pc_plus4.
//   FLUSH: flush=1; cnt>0 -> cnt-1; cnt==0 -> IDLE. npc held constant throughout.
//   Latency: flush rises the cycle after mp, stays exactly FlushCycles cycles.
//   No mp can occur in FLUSH (acc gated), so no re-trigger or overlap.
//  Stats: on mp, mispredict_cnt += 1; holds at 2**CntW-1 (no wrap).
//  Mid-operation reset: aborts FLUSH immediately; flush=0 asynchronously.
// TESTING
//  1. Reset check: rst pulse -> every if_pc gives pred_taken=0 (InitState 01),
//     flush=0, mispredict_cnt=0.
//  2. Training: 3x taken EQ (alu_out=0) at ex_pc=0x40, pred=0 -> first mp, flush 2
//     cycles, npc=ex_target=0x100; then if_pc=0x40 gives pred_taken=1 (entry 11 after
//     2 accepted updates).
//  3. Saturation: 5 not-taken at 0x80 -> entry 00; one taken -> 01, pred still 0.
//  4. Squash: mp at cycle N, then ex_valid=1 mispredicting at N+1, N+2 -> ignored:
//     mispredict_cnt +1 only, entry unchanged.
//  5. Cond types: alu_out=0xFFFF_FFFE, LT -> act_taken=1; NE -> 1; EQ -> 0;
//     00 -> 0; npc=ex_pc_plus4 when pred=1, act=0.
//  6. Alias/no-bypass: same idx read and written same cycle -> old value; rst
//     mid-FLUSH -> flush=0 at once; CntW=2 saturates at 3.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Conditional-branch resolver: per-index 2-bit saturating direction predictors,
// EX-stage condition evaluation, mispredict detection and a fixed-length flush sequence.
module branch_resolve_unit #(
    parameter int         WordSize    = 32,
    parameter int         IdxBits     = 6,
    parameter logic [1:0] InitState   = 2'b01,
    parameter int         FlushCycles = 2,
    parameter int         CntW        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WordSize-1:0] if_pc,
    output logic                pred_taken,
    input  logic                ex_valid,
    input  logic [WordSize-1:0] ex_pc,
    input  logic                ex_pred_taken,
    input  logic [1:0]          branch_cond,
    input  logic [WordSize-1:0] alu_out,
    input  logic [WordSize-1:0] ex_target,
    input  logic [WordSize-1:0] ex_pc_plus4,
    output logic                act_taken,
    output logic                flush,
    output logic [WordSize-1:0] npc,
    output logic [CntW-1:0]     mispredict_cnt
);

    localparam int Depth = 2 ** IdxBits;
    localparam int FcW   = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t              state_reg, state_next;
    logic [FcW-1:0]      fcnt_reg, fcnt_next;
    logic [WordSize-1:0] npc_reg, npc_next;
    logic [CntW-1:0]     mcnt_reg;
    logic [1:0]          ctr_reg [Depth];

    logic [IdxBits-1:0]  if_idx;
    logic [IdxBits-1:0]  ex_idx;
    logic                acc;
    logic                mp;
    logic                unused_bits;

    assign if_idx = if_pc[IdxBits+1:2];
    assign ex_idx = ex_pc[IdxBits+1:2];
    assign unused_bits = ^{if_pc[1:0], if_pc[WordSize-1:IdxBits+2],
                           ex_pc[1:0], ex_pc[WordSize-1:IdxBits+2]};

    // Asynchronous table read: a write on this edge is only seen next cycle.
    assign pred_taken = ctr_reg[if_idx][1];

    always_comb begin
        act_taken = 1'b0;
        case (branch_cond)
            2'b00:   act_taken = 1'b0;
            2'b01:   act_taken = (alu_out == '0);
            2'b10:   act_taken = (alu_out != '0);
            default: act_taken = alu_out[WordSize-1];
        endcase
    end

    // Branches arriving during a flush are wrong-path and are ignored entirely.
    assign flush = (state_reg == FLUSH);
    assign acc   = ex_valid & ~flush;
    assign mp    = acc & (act_taken != ex_pred_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                ctr_reg[i] <= InitState;
            end
        end else if (acc) begin
            if (act_taken && (ctr_reg[ex_idx] != 2'b11)) begin
                ctr_reg[ex_idx] <= ctr_reg[ex_idx] + 2'd1;
            end else if (!act_taken && (ctr_reg[ex_idx] != 2'b00)) begin
                ctr_reg[ex_idx] <= ctr_reg[ex_idx] - 2'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        fcnt_next  = fcnt_reg;
        npc_next   = npc_reg;
        case (state_reg)
            IDLE: begin
                if (mp) begin
                    state_next = FLUSH;
                    fcnt_next  = FcW'(FlushCycles - 1);
                    npc_next   = act_taken ? ex_target : ex_pc_plus4;
                end
            end
            FLUSH: begin
                if (fcnt_reg != '0) begin
                    fcnt_next = fcnt_reg - FcW'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            fcnt_reg  <= '0;
            npc_reg   <= '0;
            mcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
            npc_reg   <= npc_next;
            if (mp && (mcnt_reg != '1)) begin
                mcnt_reg <= mcnt_reg + CntW'(1);
            end
        end
    end

    assign npc            = npc_reg;
    assign mispredict_cnt = mcnt_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic checked
// against a cycle-level model of predictor table, flush window and statistics.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_pc = '0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_pred_taken = 1'b0;
    logic [1:0]  branch_cond = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] ex_target = '0;
    logic [31:0] ex_pc_plus4 = '0;

    logic        pred_taken, act_taken, flush;
    logic [31:0] npc;
    logic [15:0] mispredict_cnt;
    logic        s_pred, s_act, s_flush;
    logic [31:0] s_npc;
    logic [1:0]  s_cnt;

    int checks = 0;
    int failures = 0;

    // Reference state (main instance: FlushCycles=2, CntW=16; small: FlushCycles=1, CntW=2)
    int          m_tbl [64];
    int          m_fl;
    logic [31:0] m_npc;
    int          m_cnt;
    int          s_fl;
    int          s_cntm;

    branch_resolve_unit u_dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .branch_cond(branch_cond), .alu_out(alu_out), .ex_target(ex_target),
        .ex_pc_plus4(ex_pc_plus4), .act_taken(act_taken), .flush(flush),
        .npc(npc), .mispredict_cnt(mispredict_cnt)
    );

    branch_resolve_unit #(.CntW(2), .FlushCycles(1)) u_small (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(s_pred),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .branch_cond(branch_cond), .alu_out(alu_out), .ex_target(ex_target),
        .ex_pc_plus4(ex_pc_plus4), .act_taken(s_act), .flush(s_flush),
        .npc(s_npc), .mispredict_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic ref_act(input logic [1:0] c, input logic [31:0] a);
        if (c == 2'd0) return 1'b0;
        if (c == 2'd1) return a == 0;
        if (c == 2'd2) return a != 0;
        return $signed(a) < 0;
    endfunction

    function automatic logic ref_pred(input logic [31:0] pc);
        return m_tbl[int'(pc[7:2])] >= 2;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 64; i++) m_tbl[i] = 1;
        m_fl = 0; m_npc = '0; m_cnt = 0; s_fl = 0; s_cntm = 0;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic pt,
                         input logic [1:0] c, input logic [31:0] a,
                         input logic [31:0] tgt, input logic [31:0] ipc);
        ex_valid = v; ex_pc = pc; ex_pred_taken = pt; branch_cond = c;
        alu_out = a; ex_target = tgt; ex_pc_plus4 = pc + 32'd4; if_pc = ipc;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        logic a;
        int   i;
        a = ref_act(branch_cond, alu_out);
        i = int'(ex_pc[7:2]);
        if (m_fl > 0) begin
            m_fl--;
        end else if (ex_valid) begin
            m_tbl[i] = a ? ((m_tbl[i] < 3) ? m_tbl[i] + 1 : 3) : ((m_tbl[i] > 0) ? m_tbl[i] - 1 : 0);
            if (a != ex_pred_taken) begin
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                m_fl  = 2;
                m_npc = a ? ex_target : ex_pc_plus4;
            end
        end
        if (s_fl > 0) begin
            s_fl--;
        end else if (ex_valid && (a != ex_pred_taken)) begin
            s_fl = 1;
            s_cntm = (s_cntm < 3) ? s_cntm + 1 : s_cntm;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b0 || mispredict_cnt !== 16'd0 || npc !== 32'd0 || s_cnt !== 2'd0) begin
            failures++;
            $display("FAIL reset_state flush=%b cnt=%0d npc=%h s_cnt=%0d required 0/0/0/0",
                     flush, mispredict_cnt, npc, s_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            r = $urandom;
            if_pc = r;
            #1;
            checks++;
            if (pred_taken !== 1'b0) begin
                failures++;
                $display("FAIL reset_pred if_pc=%h got=%b required=0", r, pred_taken);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        $display("reset: done");
    endtask

    task automatic test_training();
        int cnt0;
        int fl_seen;
        cnt0 = m_cnt;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h40, 1'b0, 2'b01, 32'h0, 32'h100, 32'h40);
            #1;
            checks++;
            if (act_taken !== 1'b1) begin
                failures++;
                $display("FAIL train_act k=%0d got=%b required=1", k, act_taken);
            end
            tick();
            drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h40);
            fl_seen = 0;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (flush === 1'b1) begin
                    fl_seen++;
                    checks++;
                    if (npc !== 32'h100) begin
                        failures++;
                        $display("FAIL train_npc k=%0d got=%h required=00000100", k, npc);
                    end
                end
                tick();
            end
            checks++;
            if (fl_seen != 2) begin
                failures++;
                $display("FAIL train_flush_len k=%0d got=%0d required=2", k, fl_seen);
            end
        end
        #1;
        checks++;
        if (pred_taken !== 1'b1 || mispredict_cnt !== 16'(cnt0 + 3)) begin
            failures++;
            $display("FAIL train_result pred=%b cnt=%0d required pred=1 cnt=%0d",
                     pred_taken, mispredict_cnt, cnt0 + 3);
        end
        $display("training: pred_taken(0x40)=%b cnt=%0d", pred_taken, mispredict_cnt);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h80, 1'b0, 2'b00, $urandom, 32'h500, 32'h80);
            #1;
            checks++;
            if (flush !== 1'b0) begin
                failures++;
                $display("FAIL sat_noflush k=%0d got=%b required=0", k, flush);
            end
            tick();
        end
        drive(1'b1, 32'h80, 1'b0, 2'b01, 32'h0, 32'h500, 32'h80);
        tick();
        drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h80);
        tick();
        tick();
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL sat_floor got=%b required=0", pred_taken);
        end
        drive(1'b1, 32'h80, 1'b1, 2'b01, 32'h0, 32'h500, 32'h80);
        tick();
        drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h80);
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL sat_step_up got=%b required=1", pred_taken);
        end
        $display("saturation: pred_taken(0x80)=%b", pred_taken);
    endtask

    task automatic test_squash();
        int cnt0;
        cnt0 = m_cnt;
        drive(1'b1, 32'h100, 1'b0, 2'b01, 32'h0, 32'h600, 32'h0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'hC0, 1'b0, 2'b01, 32'h0, 32'h700, 32'hC0);
            #1;
            checks++;
            if (flush !== 1'b1) begin
                failures++;
                $display("FAIL squash_flush k=%0d got=%b required=1", k, flush);
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 32'hC0);
        #1;
        checks++;
        if (mispredict_cnt !== 16'(cnt0 + 1) || pred_taken !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL squash cnt=%0d pred=%b flush=%b required cnt=%0d pred=0 flush=0",
                     mispredict_cnt, pred_taken, flush, cnt0 + 1);
        end
        $display("squash: cnt=%0d pred_taken(0xC0)=%b", mispredict_cnt, pred_taken);
    endtask

    task automatic test_cond_types();
        logic [3:0] exp_neg;
        logic [3:0] exp_zero;
        exp_neg  = 4'b1100;  // index = cond: 00,EQ,NE,LT for alu=0xFFFFFFFE
        exp_zero = 4'b0010;  // same for alu=0
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b0, 2'(c), 32'hFFFF_FFFE, 32'h0, 32'h0);
            #1;
            checks++;
            if (act_taken !== exp_neg[c]) begin
                failures++;
                $display("FAIL cond_neg cond=%0d got=%b required=%b", c, act_taken, exp_neg[c]);
            end
            drive(1'b0, 32'h0, 1'b0, 2'(c), 32'h0, 32'h0, 32'h0);
            #1;
            checks++;
            if (act_taken !== exp_zero[c]) begin
                failures++;
                $display("FAIL cond_zero cond=%0d got=%b required=%b", c, act_taken, exp_zero[c]);
            end
        end
        drive(1'b1, 32'h200, 1'b1, 2'b01, 32'd5, 32'h300, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (flush !== 1'b1 || npc !== 32'h204) begin
            failures++;
            $display("FAIL cond_npc_fallthrough flush=%b npc=%h required flush=1 npc=00000204",
                     flush, npc);
        end
        tick();
        tick();
        $display("cond_types: npc=%h", npc);
    endtask

    task automatic test_alias();
        drive(1'b1, 32'h44, 1'b1, 2'b01, 32'h0, 32'h800, 32'h2044);
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL alias_same_cycle got=%b required=0", pred_taken);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h2044);
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL alias_next_cycle got=%b required=1", pred_taken);
        end
        $display("alias: pred_taken(0x2044) next cycle=%b", pred_taken);
    endtask

    task automatic test_reset_mid_flush();
        drive(1'b1, 32'h300, 1'b1, 2'b00, 32'h0, 32'h900, 32'h40);
        tick();
        drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h40);
        #1;
        checks++;
        if (flush !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre flush=%b required=1", flush);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b0 || npc !== 32'd0 || mispredict_cnt !== 16'd0 || pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL midrst flush=%b npc=%h cnt=%0d pred=%b required 0/0/0/0",
                     flush, npc, mispredict_cnt, pred_taken);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        $display("reset_mid_flush: flush=%b", flush);
    endtask

    task automatic test_small_sat();
        int exp_cnt;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 32'h400, 1'b0, 2'b01, 32'h0, 32'hA00, 32'h0);
            tick();
            drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
            #1;
            checks++;
            if (s_flush !== 1'b1) begin
                failures++;
                $display("FAIL small_flush_on k=%0d got=%b required=1", k, s_flush);
            end
            tick();
            exp_cnt = (k < 3) ? k : 3;
            #1;
            checks++;
            if (s_flush !== 1'b0 || s_cnt !== 2'(exp_cnt) || mispredict_cnt !== 16'(k)) begin
                failures++;
                $display("FAIL small_sat k=%0d s_flush=%b s_cnt=%0d cnt=%0d required 0/%0d/%0d",
                         k, s_flush, s_cnt, mispredict_cnt, exp_cnt, k);
            end
            tick();
            $display("small_sat: k=%0d s_cnt=%0d", k, s_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, pc, ipc, a;
        logic        e_act;
        for (int n = 0; n < 400; n++) begin
            r   = $urandom;
            pc  = (r & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
            r   = $urandom;
            ipc = (r & 32'hFFFF_FF03) | (32'($urandom_range(0, 7)) << 2);
            case ($urandom_range(0, 3))
                0: a = 32'h0;
                1: a = 32'h1;
                2: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            drive(1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), a, $urandom, ipc);
            #1;
            e_act = ref_act(branch_cond, alu_out);
            checks++;
            if (pred_taken !== ref_pred(ipc) || act_taken !== e_act) begin
                failures++;
                $display("FAIL rnd_comb n=%0d pred=%b act=%b required pred=%b act=%b",
                         n, pred_taken, act_taken, ref_pred(ipc), e_act);
            end
            checks++;
            if (flush !== (m_fl > 0) || (m_fl > 0 && npc !== m_npc) ||
                mispredict_cnt !== 16'(m_cnt)) begin
                failures++;
                $display("FAIL rnd_state n=%0d flush=%b npc=%h cnt=%0d required flush=%b npc=%h cnt=%0d",
                         n, flush, npc, mispredict_cnt, m_fl > 0, m_npc, m_cnt);
            end
            checks++;
            if (s_flush !== (s_fl > 0) || s_cnt !== 2'(s_cntm)) begin
                failures++;
                $display("FAIL rnd_small n=%0d s_flush=%b s_cnt=%0d required %b/%0d",
                         n, s_flush, s_cnt, s_fl > 0, s_cntm);
            end
            tick();
        end
        $display("random: 400 cycles, cnt=%0d", mispredict_cnt);
    endtask

    initial begin
        reset_model();
        @(negedge clk);
        test_reset();
        test_training();
        test_saturation();
        test_squash();
        test_cond_types();
        test_alias();
        test_reset_mid_flush();
        test_small_sat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
